// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the unified-memory arbiter.
//   state_t         : arbiter FSM state encoding
//   TIMEOUT_DATA    : read data returned when the memory never answers
//   DEFAULT_TIMEOUT : default number of WAIT cycles before giving up
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA    = 32'hDEADBEEF;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// WAIT-cycle watchdog for the memory arbiter.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   en      : count this cycle (FSM is in WAIT)
//   clr     : clear the count (FSM is not in WAIT)
//   expired : count has reached TIMEOUT while enabled
module mem_arbiter_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch (I) and load/store (D) ports onto a
// single-port unified memory, one outstanding transaction at a time.
//   clk, reset                   : clock, asynchronous active-low reset
//   i_req/i_addr -> i_rdata/i_done : fetch request and response
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done : load/store request/response
//   m_req/m_we/m_addr/m_wdata    : memory command (m_req one cycle in ISSUE)
//   m_rdata/m_done               : memory response
//   stall                        : pipeline freeze while a request is pending
//   err                          : sticky memory-timeout flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  output logic              stall,
  output logic              err
);

  localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(TIMEOUT_DATA);

  state_t            state, state_nx;
  logic              prio_d;
  logic              owner;      // 1 = D owns the transaction
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              err_q;
  logic              grant, grant_d;
  logic              expired;
  logic              finish;

  mem_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .en      (state == WAIT),
    .clr     (state != WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant    = 1'b1;
          grant_d  = d_req && (!i_req || prio_d);
          state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (m_done || expired) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // m_done takes precedence over expiry when both land in the same cycle.
  assign finish = (state == WAIT) && (m_done || expired);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_d    <= 1'b1;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant) begin
        owner     <= grant_d;
        cmd_we    <= grant_d && d_we;
        cmd_addr  <= grant_d ? d_addr : i_addr;
        cmd_wdata <= grant_d ? d_wdata : '0;
        prio_d    <= !grant_d;
      end
      if (finish && !cmd_we) begin
        if (owner) d_rdata_q <= m_done ? m_rdata : TO_DATA;
        else       i_rdata_q <= m_done ? m_rdata : TO_DATA;
      end
      if (finish && !m_done) err_q <= 1'b1;
    end
  end

  assign m_req   = (state == ISSUE);
  assign m_we    = cmd_we;
  assign m_addr  = cmd_addr;
  assign m_wdata = cmd_wdata;
  assign i_done  = (state == RESP) && !owner;
  assign d_done  = (state == RESP) && owner;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
  assign stall   = (i_req && !i_done) || (d_req && !d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_done = 1'b0;
  logic        stall;
  logic        err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int mreq_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // memory model
  logic [31:0] mem [logic [31:0]];
  int          mem_delay = 1;
  bit          mem_on    = 1'b1;
  bit          mem_early = 1'b0;
  int          pend      = 0;
  logic [31:0] pend_data = '0;

  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_done  = 1'b1;
        m_rdata = pend_data;
      end
    end
    if (m_req && mem_on) begin
      if (mem_early) begin
        m_done  = 1'b1;
        m_rdata = 32'hBAD0BAD0;
      end
      if (m_we) begin
        mem[m_addr] = m_wdata;
        pend_data   = 32'($urandom);
      end else begin
        pend_data = mem[m_addr];
      end
      pend = mem_delay;
    end
  end

  // scoreboard
  typedef struct { bit is_d; logic [31:0] data; } sb_t;
  sb_t sb[$];

  always @(posedge clk) begin
    sb_t e;
    #1;
    if (m_req) mreq_cnt++;
    if (i_done || d_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {62'd0, i_done, d_done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_owner", {62'd0, i_done, d_done}, e.is_d ? 64'd1 : 64'd2);
        check("rdata", e.is_d ? {32'd0, d_rdata} : {32'd0, i_rdata}, {32'd0, e.data});
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          early;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    sb_t e;
    bit  seen = 1'b0;
    @(posedge clk); #1;
    mem_delay = v.delay;
    mem_early = v.early;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    e.is_d = v.is_d;
    e.data = v.exp_data;
    sb.push_back(e);
    for (int lat = 1; lat < 60 && !seen; lat++) begin
      @(posedge clk); #2;
      if (lat == 1) begin
        check("issue_m_req", {63'd0, m_req}, 64'd1);
        check("issue_stall", {63'd0, stall}, 64'd1);
        check("issue_m_addr", {32'd0, m_addr}, {32'd0, v.addr});
        check("issue_m_we", {63'd0, m_we}, {63'd0, v.is_d && v.we});
        if (v.is_d) check("issue_m_wdata", {32'd0, m_wdata}, {32'd0, v.wdata});
      end
      if (i_done || d_done) begin
        seen = 1'b1;
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("done_stall", {63'd0, stall}, 64'd0);
        check("held_m_addr", {32'd0, m_addr}, {32'd0, v.addr});
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    if (!seen) check("done_wait", 64'd0, 64'd1);
    mem_early = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int base, n;
    vec_t v;
    mem[32'h40]  = 32'h2010_0005;
    mem[32'h54]  = 32'h0;
    mem[32'h80]  = 32'hCAFE_F00D;
    mem[32'h100] = 32'h1111_0000;
    mem[32'h200] = 32'h2222_0000;

    //           is_d we addr      wdata      dly early exp_data       lat
    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,     1, 1'b0, 32'h2010_0005, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h54, 32'h7,     1, 1'b0, 32'h0,         3};
    vecs[2] = '{1'b1, 1'b0, 32'h54, 32'h0,     1, 1'b0, 32'h7,         3};
    vecs[3] = '{1'b1, 1'b1, 32'h54, 32'h1234,  2, 1'b0, 32'h7,         4};
    vecs[4] = '{1'b0, 1'b0, 32'h80, 32'h0,     4, 1'b1, 32'hCAFE_F00D, 6};
    vecs[5] = '{1'b1, 1'b0, 32'h54, 32'h0,     3, 1'b0, 32'h1234,      5};
    vecs[6] = '{1'b0, 1'b0, 32'h40, 32'h0,     1, 1'b0, 32'h2010_0005, 3};

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_m_req", {63'd0, m_req}, 64'd0);
    check("rst_done", {62'd0, i_done, d_done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    check("rst_cmd", {31'd0, m_we, m_addr}, 64'd0);
    check("rst_stall_idle", {63'd0, stall}, 64'd0);
    i_req = 1'b1; #1;
    check("rst_stall_req", {63'd0, stall}, 64'd1);
    i_req = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // m_done in the same cycle the watchdog expires
    v = '{1'b1, 1'b0, 32'h54, 32'h0, T + 1, 1'b0, 32'h1234, T + 3};
    run_vec(v);
    check("boundary_err", {63'd0, err}, 64'd0);

    // timeout with no response
    mem_on = 1'b0;
    v = '{1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, T + 3};
    run_vec(v);
    check("timeout_err", {63'd0, err}, 64'd1);
    mem_on = 1'b1;
    run_vec(vecs[0]);
    check("err_sticky", {63'd0, err}, 64'd1);

    // reset during WAIT; the late m_done then lands in IDLE
    mem_delay = 10;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h80;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(posedge clk); #2;
      if (m_req) n = 1;
    end
    check("rstmid_issue", 64'(n), 64'd1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid_m_req", {63'd0, m_req}, 64'd0);
    check("rstmid_done", {62'd0, i_done, d_done}, 64'd0);
    check("rstmid_err", {63'd0, err}, 64'd0);
    check("rstmid_stall", {63'd0, stall}, 64'd1);
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    base = mreq_cnt;
    repeat (10) @(posedge clk);
    #2;
    check("rstmid_no_mreq", 64'(mreq_cnt - base), 64'd0);
    mem_delay = 1;
    run_vec(vecs[0]);
    check("rstmid_fresh_err", {63'd0, err}, 64'd0);

    // contention: D, I, D, I
    base = mreq_cnt;
    @(posedge clk); #1;
    mem_delay = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      sb_t e;
      e.is_d = (k % 2 == 0);
      e.data = e.is_d ? 32'h1111_0000 : 32'h2222_0000;
      sb.push_back(e);
    end
    n = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(posedge clk); #2;
      if (i_done || d_done) n++;
      if (n == 4) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    check("contention_dones", 64'(n), 64'd4);
    repeat (4) @(posedge clk);
    #2;
    check("contention_mreq", 64'(mreq_cnt - base), 64'd4);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles allowed for a memory response.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1, meaning asynchronous, active-low reset.
REQ-006 The block SHALL have ports i_req (input, 1) and i_addr (input, ADDR_W), meaning the instruction-fetch read request.
REQ-007 The block SHALL have ports i_rdata (output, DATA_W) and i_done (output, 1), meaning the fetch response data and its one-cycle completion pulse.
REQ-008 The block SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, ADDR_W) and d_wdata (input, DATA_W), meaning the load/store request.
REQ-009 The block SHALL have ports d_rdata (output, DATA_W) and d_done (output, 1), meaning the load/store response data and its one-cycle completion pulse.
REQ-010 The block SHALL have ports m_req (output, 1), m_we (output, 1), m_addr (output, ADDR_W) and m_wdata (output, DATA_W), meaning the command to the single-port unified memory.
REQ-011 The block SHALL have ports m_rdata (input, DATA_W) and m_done (input, 1), meaning the memory response.
REQ-012 The block SHALL have port stall, output, width 1, meaning pipeline freeze.
REQ-013 The block SHALL have port err, output, width 1, meaning a sticky memory-timeout flag.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP; it holds one outstanding memory transaction at most.
REQ-015 In IDLE with exactly one of i_req/d_req high, that requester SHALL be granted and the FSM SHALL go to ISSUE next cycle.
REQ-016 In IDLE with both requests high, the grant SHALL go to D when prio_d=1, else to I.
REQ-017 prio_d SHALL be set to 0 after each D grant and to 1 after each I grant, so that D and I alternate under contention.
REQ-018 On grant, address, we (forced 0 for I) and wdata SHALL be latched into command registers, and the owner bit SHALL be recorded.
REQ-019 m_req SHALL be 1 only in ISSUE, exactly one cycle per transaction.
REQ-020 m_we, m_addr and m_wdata SHALL be driven from the command registers and held constant from ISSUE through RESP.
REQ-021 ISSUE SHALL always go to WAIT; m_done in ISSUE SHALL be ignored, because memory responds no earlier than the cycle after m_req.
REQ-022 In WAIT, m_done=1 SHALL cause a transition to RESP; on a read, m_rdata SHALL be captured into the owner's rdata register.
REQ-023 The rdata registers SHALL hold their value until the next read by the same owner; writes SHALL leave d_rdata unchanged.
REQ-024 In RESP, the owner's done SHALL be 1 for exactly one cycle and the FSM SHALL go to IDLE next cycle.
REQ-025 Requests SHALL be sampled only in IDLE, so a requester that drops req after done is never double-granted.
REQ-026 With no memory wait, latency SHALL be req at cycle 0 -> m_req at cycle 1 -> m_done at cycle 2 -> done at cycle 3 -> IDLE at cycle 4.
REQ-027 A watchdog SHALL count WAIT cycles from 0.
REQ-028 If the watchdog reaches TIMEOUT without m_done, the FSM SHALL go to RESP, the owner's rdata (on a read) SHALL load 32'hDEADBEEF, and err SHALL set.
REQ-029 err SHALL remain set until reset; the watchdog SHALL clear on leaving WAIT.
REQ-030 m_done arriving in the same cycle the watchdog reaches TIMEOUT SHALL be treated as a normal response: no err, real data.
REQ-031 stall SHALL be combinational: (i_req & ~i_done) | (d_req & ~d_done).
REQ-032 Request inputs changing outside IDLE SHALL have no effect on the transaction in flight.

Reset
REQ-033 reset low SHALL immediately force IDLE, m_req=0, i_done=d_done=0, err=0, prio_d=1, watchdog=0, command and rdata registers=0.
REQ-034 Any transaction in flight when reset asserts SHALL be abandoned without a done pulse; an m_done arriving after deassertion in IDLE SHALL be ignored.
REQ-035 While reset is low, stall SHALL still follow REQ-031 from the inputs.

Structure
REQ-036 The state encodings, the timeout data constant 32'hDEADBEEF and the default TIMEOUT SHALL live in the shared simulation/parameter header used by the CPU.
REQ-037 The watchdog counter SHALL be one sub-module, mem_arbiter_watchdog (inputs: clk, reset, en, clr; output: expired); everything else SHALL be flat.

Verification
REQ-038 Verify the single fetch: i_req=1, i_addr=0x40, with m_done one cycle after m_req and m_rdata=0x2010_0005 -> m_req at cycle 1, i_done at cycle 3 with i_rdata=0x2010_0005, and stall low at cycle 3.
REQ-039 Verify the store: d_req=1, d_we=1, d_addr=0x54, d_wdata=7 -> m_we=1, m_addr=0x54, m_wdata=7 in ISSUE, d_done one cycle after m_done, and d_rdata unchanged.
REQ-040 Verify contention: i_req and d_req held high for four transactions -> grant order D, I, D, I, with exactly one m_req pulse per transaction.
REQ-041 Verify the timeout: d_req read with m_done never asserted -> d_done at TIMEOUT+3 cycles after req, d_rdata=0xDEADBEEF, err=1 until reset.
REQ-042 Verify reset mid-operation: reset low during WAIT -> m_req=0, no done pulse; after release, a fresh i_req completes normally with err=0.
REQ-043 Verify the boundary case: m_done coincident with watchdog expiry -> real data returned and err=0.
